fpu_op_scheduler: RTL

- Single-issue dispatcher and result collector for the four FP operation units: ADD, SUB, MUL and DIV.
- Accepts operation requests over a valid/ready handshake and routes each one to the unit selected by its opcode.
- For SUB, inverts the sign of operand B on dispatch.
- Tracks each unit's busy/done state with a timeout watchdog and returns results in round-robin order through a one-entry output buffer.

---
 rtl/fpu_op_scheduler.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/fpu_op_scheduler.sv
// Single-issue dispatcher for the ADD/SUB/MUL/DIV units: per-unit IDLE/BUSY/DONE tracking with a
// timeout watchdog, and a one-entry result buffer filled from DONE units in round-robin order.
module fpu_op_scheduler #(
  parameter int          TAG_W   = 4,
  parameter int          TIMEOUT = 64,
  parameter logic [31:0] NAN_VAL = 32'h7FC00000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [3:0]       unit_start,
  output logic [31:0]      unit_a,
  output logic [31:0]      unit_b,
  input  logic [3:0]       unit_done,
  input  logic [127:0]     unit_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic [1:0]       res_op,
  output logic             res_err
);
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [1:0] OP_SUB = 2'd1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} ustate_t;

  ustate_t          state_q [4];
  logic [CNT_W-1:0] cnt_q   [4];
  logic [TAG_W-1:0] tag_q   [4];
  logic [31:0]      data_q  [4];
  logic [3:0]       err_q;
  logic [1:0]       ptr_q;

  logic [3:0]       unit_start_q;
  logic [31:0]      unit_a_q;
  logic [31:0]      unit_b_q;
  logic             res_valid_q;
  logic [31:0]      res_data_q;
  logic [TAG_W-1:0] res_tag_q;
  logic [1:0]       res_op_q;
  logic             res_err_q;

  logic             accept;
  logic             load;
  logic             any_done;
  logic [1:0]       sel;
  logic [1:0]       idx;

  assign req_ready = (state_q[req_op] == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // Scan offsets high to low so the DONE unit closest above the pointer is the last one written.
  always_comb begin
    any_done = 1'b0;
    sel      = ptr_q;
    idx      = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (state_q[idx] == DONE) begin
        any_done = 1'b1;
        sel      = idx;
      end
    end
  end

  assign load = any_done && (!res_valid_q || res_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
      end
      err_q        <= '0;
      ptr_q        <= '0;
      unit_start_q <= '0;
      unit_a_q     <= '0;
      unit_b_q     <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_tag_q    <= '0;
      res_op_q     <= '0;
      res_err_q    <= 1'b0;
    end else begin
      unit_start_q <= '0;
      if (accept) begin
        unit_start_q[req_op] <= 1'b1;
        unit_a_q             <= req_a;
        unit_b_q             <= (req_op == OP_SUB) ? {~req_b[31], req_b[30:0]} : req_b;
      end

      for (int i = 0; i < 4; i++) begin
        case (state_q[i])
          IDLE: begin
            if (accept && (req_op == 2'(i))) begin
              state_q[i] <= BUSY;
              cnt_q[i]   <= '0;
              tag_q[i]   <= req_tag;
            end
          end
          BUSY: begin
            // A real completion beats the watchdog when both land in the same cycle.
            if (unit_done[i]) begin
              state_q[i] <= DONE;
              data_q[i]  <= unit_result[32*i +: 32];
              err_q[i]   <= 1'b0;
            end else if (cnt_q[i] == CNT_W'(TIMEOUT - 1)) begin
              state_q[i] <= DONE;
              data_q[i]  <= NAN_VAL;
              err_q[i]   <= 1'b1;
            end else begin
              cnt_q[i] <= cnt_q[i] + 1'b1;
            end
          end
          DONE: begin
            if (load && (sel == 2'(i))) state_q[i] <= IDLE;
          end
          default: state_q[i] <= IDLE;
        endcase
      end

      if (load) begin
        res_valid_q <= 1'b1;
        res_data_q  <= data_q[sel];
        res_tag_q   <= tag_q[sel];
        res_op_q    <= sel;
        res_err_q   <= err_q[sel];
        ptr_q       <= sel + 2'd1;
      end else if (res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign unit_start = unit_start_q;
  assign unit_a     = unit_a_q;
  assign unit_b     = unit_b_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_tag    = res_tag_q;
  assign res_op     = res_op_q;
  assign res_err    = res_err_q;

endmodule
